ttt_move_gen: RTL and testbench

- Computer-opponent move generator for the tic-tac-toe game controller; the producer side of the controller's computer-move input.
- On request, snapshots the board and scans it over multiple cycles. Priority order: winning move, then blocking move, then a positional fallback.
- Presents a legal 1-based position on comp_pos under a valid/ack handshake.
- Sits beside the game FSM. The FSM drives board and req; this block drives comp_pos.

---
 rtl/ttt_pkg.sv | 45 ++++
 rtl/ttt_line_check.sv | 34 +++
 rtl/ttt_move_gen.sv | 126 ++++++++++++
 tb/tb_ttt_move_gen.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// rtl/ttt_pkg.sv - shared cell codes, line table, pick order and FSM states for the move generator
// No ports: constants, state type and a board cell accessor.
package ttt_pkg;

    localparam logic [1:0] CELL_EMPTY  = 2'b00;
    localparam logic [1:0] CELL_PLAYER = 2'b01;
    localparam logic [1:0] CELL_COMP   = 2'b10;
    localparam logic [1:0] CELL_OCC    = 2'b11;

    // Eight winning lines as cell-index triples; element 0 is the last entry below.
    localparam logic [7:0][2:0][3:0] LINES = {
        {4'd2, 4'd4, 4'd6},   // anti-diagonal
        {4'd0, 4'd4, 4'd8},   // diagonal
        {4'd2, 4'd5, 4'd8},   // column 2
        {4'd1, 4'd4, 4'd7},   // column 1
        {4'd0, 4'd3, 4'd6},   // column 0
        {4'd6, 4'd7, 4'd8},   // row 2
        {4'd3, 4'd4, 4'd5},   // row 1
        {4'd0, 4'd1, 4'd2}    // row 0
    };

    // Positional fallback: center, corners, edges. PICK_ORDER[0] is the center.
    localparam logic [8:0][3:0] PICK_ORDER = {
        4'd7, 4'd5, 4'd3, 4'd1, 4'd8, 4'd6, 4'd2, 4'd0, 4'd4
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN_WIN,
        ST_SCAN_BLOCK,
        ST_PICK,
        ST_DONE
    } state_t;

    // Out-of-range indices read as occupied so they can never be chosen.
    function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] i);
        logic [1:0] c;
        c = CELL_OCC;
        for (int k = 0; k < 9; k++) begin
            if (i == k[3:0]) c = b[2*k +: 2];
        end
        return c;
    endfunction

endpackage

// File: rtl/ttt_line_check.sv
// rtl/ttt_line_check.sv - combinational test of whether a cell completes a line for a given mark
// Ports: board (18b snapshot), idx (cell 0..8), mark (2b cell code) -> hit.
module ttt_line_check
    import ttt_pkg::*;
(
    input  logic [17:0] board,
    input  logic [3:0]  idx,
    input  logic [1:0]  mark,
    output logic        hit
);

    logic       line_hit;
    logic       on_line;
    logic [1:0] cnt;

    // The candidate cell is empty, so it never counts towards the mark; a line
    // through it with two mark cells therefore has exactly its other two cells set.
    always_comb begin
        line_hit = 1'b0;
        on_line  = 1'b0;
        cnt      = 2'd0;
        for (int l = 0; l < 8; l++) begin
            on_line = 1'b0;
            cnt     = 2'd0;
            for (int p = 0; p < 3; p++) begin
                if (LINES[l][p] == idx) on_line = 1'b1;
                if (cell_at(board, LINES[l][p]) == mark) cnt = cnt + 2'd1;
            end
            if (on_line && cnt == 2'd2) line_hit = 1'b1;
        end
        hit = (cell_at(board, idx) == CELL_EMPTY) && line_hit;
    end

endmodule

// File: rtl/ttt_move_gen.sv
// rtl/ttt_move_gen.sv - multi-cycle computer move generator: win scan, block scan, positional pick
// Ports: clk, rst_n (async active-low), board[17:0], req, move_ack in;
//        comp_pos[3:0] (1..9, 0 = none), move_valid, no_move, busy out.
module ttt_move_gen
    import ttt_pkg::*;
#(
    parameter bit EN_BLOCK = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [17:0] board,
    input  logic        req,
    input  logic        move_ack,
    output logic [3:0]  comp_pos,
    output logic        move_valid,
    output logic        no_move,
    output logic        busy
);

    state_t      state;
    logic [3:0]  idx;
    logic [17:0] snapshot;
    logic [1:0]  mark;
    logic        hit;
    logic        board_full;
    logic [3:0]  pick_idx;

    // One checker serves both passes; the mark follows the current pass.
    assign mark = (state == ST_SCAN_BLOCK) ? CELL_PLAYER : CELL_COMP;

    ttt_line_check u_line_check (
        .board (snapshot),
        .idx   (idx),
        .mark  (mark),
        .hit   (hit)
    );

    // Fullness is judged on the live board because it is the value being captured.
    always_comb begin
        board_full = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (board[2*k +: 2] == CELL_EMPTY) board_full = 1'b0;
        end
    end

    // Walk the order backwards so the earliest empty entry wins.
    always_comb begin
        pick_idx = 4'd4;
        for (int k = 8; k >= 0; k--) begin
            if (cell_at(snapshot, PICK_ORDER[k]) == CELL_EMPTY) pick_idx = PICK_ORDER[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= 4'd0;
            snapshot   <= 18'd0;
            comp_pos   <= 4'd0;
            move_valid <= 1'b0;
            no_move    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        snapshot <= board;
                        idx      <= 4'd0;
                        busy     <= 1'b1;
                        if (board_full) begin
                            comp_pos   <= 4'd0;
                            no_move    <= 1'b1;
                            move_valid <= 1'b1;
                            state      <= ST_DONE;
                        end else begin
                            state <= ST_SCAN_WIN;
                        end
                    end
                end
                ST_SCAN_WIN: begin
                    if (hit) begin
                        comp_pos   <= idx + 4'd1;
                        move_valid <= 1'b1;
                        state      <= ST_DONE;
                    end else if (idx != 4'd8) begin
                        idx <= idx + 4'd1;
                    end else begin
                        idx   <= 4'd0;
                        state <= EN_BLOCK ? ST_SCAN_BLOCK : ST_PICK;
                    end
                end
                ST_SCAN_BLOCK: begin
                    if (hit) begin
                        comp_pos   <= idx + 4'd1;
                        move_valid <= 1'b1;
                        state      <= ST_DONE;
                    end else if (idx != 4'd8) begin
                        idx <= idx + 4'd1;
                    end else begin
                        idx   <= 4'd0;
                        state <= ST_PICK;
                    end
                end
                ST_PICK: begin
                    comp_pos   <= pick_idx + 4'd1;
                    move_valid <= 1'b1;
                    state      <= ST_DONE;
                end
                ST_DONE: begin
                    if (move_ack) begin
                        comp_pos   <= 4'd0;
                        move_valid <= 1'b0;
                        no_move    <= 1'b0;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ttt_move_gen.sv
// tb/tb_ttt_move_gen.sv - directed self-checking bench for ttt_move_gen (block pass on and off)
module tb_ttt_move_gen;

    localparam logic [1:0] E = 2'b00;
    localparam logic [1:0] P = 2'b01;
    localparam logic [1:0] C = 2'b10;
    localparam logic [1:0] X = 2'b11;

    logic        clk;
    logic        rst_n;
    logic [17:0] board;
    logic        req0, req1, ack0, ack1;
    logic [3:0]  cp0, cp1;
    logic        mv0, mv1, nm0, nm1, bz0, bz1;

    int n_vec;
    int n_err;

    ttt_move_gen #(.EN_BLOCK(1'b1)) dut_hard (
        .clk (clk), .rst_n (rst_n), .board (board), .req (req0), .move_ack (ack0),
        .comp_pos (cp0), .move_valid (mv0), .no_move (nm0), .busy (bz0)
    );

    ttt_move_gen #(.EN_BLOCK(1'b0)) dut_easy (
        .clk (clk), .rst_n (rst_n), .board (board), .req (req1), .move_ack (ack1),
        .comp_pos (cp1), .move_valid (mv1), .no_move (nm1), .busy (bz1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] bd(input logic [1:0] c0, c1, c2, c3, c4, c5, c6, c7, c8);
        return {c8, c7, c6, c5, c4, c3, c2, c1, c0};
    endfunction

    function automatic logic [6:0] outs(input int w);
        return (w == 0) ? {cp0, mv0, nm0, bz0} : {cp1, mv1, nm1, bz1};
    endfunction

    function automatic logic valid_of(input int w);
        return (w == 0) ? mv0 : mv1;
    endfunction

    // lat = number of clock edges after the request edge before move_valid is seen
    task automatic request(input int w, input logic [17:0] b, output int lat);
        @(negedge clk);
        board = b;
        if (w == 0) req0 = 1'b1; else req1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
        lat  = 0;
        while (!valid_of(w) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic acknowledge(input int w, input string tag);
        @(negedge clk);
        if (w == 0) ack0 = 1'b1; else ack1 = 1'b1;
        @(negedge clk);
        ack0 = 1'b0;
        ack1 = 1'b0;
        check(tag, outs(w), 7'd0);
    endtask

    logic [17:0] b_win, b_block, b_empty, b_center, b_full;
    int lat;

    initial begin
        n_vec = 0;
        n_err = 0;
        clk   = 1'b0;
        rst_n = 1'b1;
        board = 18'd0;
        req0  = 1'b0; req1 = 1'b0;
        ack0  = 1'b0; ack1 = 1'b0;

        b_win    = bd(C, C, E, P, P, E, E, E, E);
        b_block  = bd(P, C, E, E, P, E, E, E, E);
        b_empty  = 18'd0;
        b_center = bd(E, E, E, E, P, E, E, E, E);
        b_full   = bd(P, C, P, P, C, C, C, P, X);

        #1 rst_n = 1'b0;
        #1;
        check("reset_hard", outs(0), 7'd0);
        check("reset_easy", outs(1), 7'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Win beats block; then hold without ack and pulse req while in DONE.
        request(0, b_win, lat);
        check("win_lat", lat, 3);
        check("win_pos", cp0, 4'd3);
        check("win_nomove", nm0, 1'b0);
        check("win_busy", bz0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req0 = (i == 2);
            check("hold", {cp0, mv0, nm0, bz0}, {4'd3, 1'b1, 1'b0, 1'b1});
        end
        req0 = 1'b0;
        acknowledge(0, "win_ack");
        @(negedge clk);
        check("idle_after_ack", bz0, 1'b0);

        request(0, b_block, lat);
        check("block_lat", lat, 18);
        check("block_pos", cp0, 4'd9);
        acknowledge(0, "block_ack");

        request(1, b_block, lat);
        check("easy_lat", lat, 10);
        check("easy_pos", cp1, 4'd3);
        acknowledge(1, "easy_ack");

        request(0, b_empty, lat);
        check("empty_lat", lat, 19);
        check("empty_pos", cp0, 4'd5);
        acknowledge(0, "empty_ack");

        request(0, b_center, lat);
        check("center_lat", lat, 19);
        check("center_pos", cp0, 4'd1);
        acknowledge(0, "center_ack");

        request(0, b_full, lat);
        check("full_lat", lat, 0);
        check("full_nomove", nm0, 1'b1);
        check("full_pos", cp0, 4'd0);
        acknowledge(0, "full_ack");

        // Board mutated and req held during SCAN_WIN: result follows the snapshot.
        @(negedge clk);
        board = b_win;
        req0  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        board = b_empty;
        lat   = 0;
        while (!mv0 && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 1) req0 = 1'b0;
        end
        req0 = 1'b0;
        check("snap_lat", lat, 3);
        check("snap_pos", cp0, 4'd3);
        acknowledge(0, "snap_ack");

        // Asynchronous reset in the middle of SCAN_BLOCK.
        @(negedge clk);
        board = b_empty;
        req0  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req0 = 1'b0;
        repeat (12) @(negedge clk);
        check("midscan_busy", bz0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("midscan_reset", outs(0), 7'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset while holding a result in DONE.
        request(0, b_win, lat);
        check("pre_reset_valid", mv0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("done_reset", outs(0), 7'd0);
        @(negedge clk);
        rst_n = 1'b1;

        request(0, b_win, lat);
        check("restart_lat", lat, 3);
        check("restart_pos", cp0, 4'd3);
        acknowledge(0, "restart_ack");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
